// File: rtl/tsxb_pkg.sv
// rtl/tsxb_pkg.sv - shared constants and types for the TSXB port decoder
package tsxb_pkg;

    localparam logic [7:0] TSXB_LO_DEF  = 8'hAF;
    localparam logic [7:0] REG_BASE_DEF = 8'h80;
    localparam logic [7:0] COVOX_LO     = 8'hFB;
    // Soundrive channel ports, index k = channel k
    localparam logic [3:0][7:0] SD_LO   = {8'h5F, 8'h4F, 8'h1F, 8'h0F};

    localparam logic [7:0] ID_HI_A   = 8'h01;
    localparam logic [7:0] ID_VAL_A  = 8'hAA;
    localparam logic [7:0] ID_HI_B   = 8'h02;
    localparam logic [7:0] ID_VAL_B  = 8'h55;
    localparam logic [7:0] STATUS_HI = 8'h03;

    localparam logic [7:0] DAC_MID = 8'h80;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_ID,
        RD_STATUS,
        RD_REG
    } rd_sel_e;

endpackage

// File: rtl/tsxb_dac_buf.sv
// rtl/tsxb_dac_buf.sv - double-buffered multi-channel DAC latch with sample tick
module tsxb_dac_buf
    import tsxb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_we,
    input  logic [7:0]            wr_data,
    output logic [8*NUM_CH-1:0]   dac_out,
    output logic [NUM_CH-1:0]     dirty,
    output logic                  sample_tick
);

    localparam int CW = (SAMPLE_DIV > 0) ? $clog2(SAMPLE_DIV + 1) : 1;
    localparam logic [CW-1:0] DIV = CW'(SAMPLE_DIV);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     tick_q, tick_d;
    logic [NUM_CH-1:0]        dirty_q, dirty_d;
    logic [NUM_CH-1:0][7:0]   pend_q, pend_d;
    logic [NUM_CH-1:0][7:0]   out_q, out_d;

    always_comb begin
        cnt_d   = (cnt_q == DIV) ? '0 : cnt_q + CW'(1);
        tick_d  = (cnt_d == DIV);
        pend_d  = pend_q;
        dirty_d = tick_q ? '0 : dirty_q;
        // A tick publishes the pending values as they stood before this cycle's write
        out_d   = tick_q ? pend_q : out_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_we[k]) begin
                pend_d[k] = wr_data;
                if (SAMPLE_DIV > 0) dirty_d[k] = 1'b1;
            end
        end
        if (SAMPLE_DIV == 0) out_d = pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            dirty_q <= '0;
            pend_q  <= {NUM_CH{DAC_MID}};
            out_q   <= {NUM_CH{DAC_MID}};
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            dirty_q <= dirty_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

    assign dac_out     = out_q;
    assign dirty       = dirty_q;
    assign sample_tick = tick_q;

endmodule

// File: rtl/tsxb_port_regs.sv
// rtl/tsxb_port_regs.sv - TSXB port decoder, register bank and DAC latch top
module tsxb_port_regs
    import tsxb_pkg::*;
#(
    parameter logic [7:0] TSXB_LO    = TSXB_LO_DEF,
    parameter logic [7:0] REG_BASE   = REG_BASE_DEF,
    parameter int         NUM_REGS   = 4,
    parameter int         NUM_CH     = 4,
    parameter int         SAMPLE_DIV = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             addr,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    input  logic                    rnw,
    input  logic                    port_req,
    output logic                    port_en,
    output logic                    port_stb,
    output logic [8*NUM_REGS-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]     reg_wstb,
    output logic [8*NUM_CH-1:0]     dac_out,
    output logic                    sample_tick
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] REG_END = {1'b0, REG_BASE} + 9'(NUM_REGS);

    if (NUM_REGS < 1 || NUM_REGS > 32 || int'(REG_BASE) + NUM_REGS > 256
        || NUM_CH < 1 || NUM_CH > 4) begin : g_param_err
        $error("tsxb_port_regs: NUM_REGS/REG_BASE/NUM_CH out of range");
    end

    logic                       req_q, req_d;
    logic                       stb_q, stb_d;
    logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]        wstb_q, wstb_d;

    logic [7:0]         loa, hia, reg_off, status;
    logic               win, cov, reg_hit, wr_act, iord_en, iowr_en;
    logic [3:0]         sd_hit;
    logic [IW-1:0]      reg_idx;
    logic [NUM_CH-1:0]  ch_we, dirty;
    rd_sel_e            rd_sel;

    assign loa     = addr[7:0];
    assign hia     = addr[15:8];
    assign win     = (loa == TSXB_LO);
    assign cov     = (loa == COVOX_LO);
    assign reg_hit = ({1'b0, hia} >= {1'b0, REG_BASE}) && ({1'b0, hia} < REG_END);
    assign reg_off = hia - REG_BASE;
    assign reg_idx = reg_off[IW-1:0];
    assign wr_act  = stb_q & ~rnw;

    always_comb begin
        for (int k = 0; k < 4; k++) sd_hit[k] = (loa == SD_LO[k]);
        rd_sel = RD_NONE;
        if (win) begin
            if (hia == ID_HI_A || hia == ID_HI_B) rd_sel = RD_ID;
            else if (hia == STATUS_HI)            rd_sel = RD_STATUS;
            else if (reg_hit)                     rd_sel = RD_REG;
        end
    end

    always_comb begin
        status = 8'h00;
        status[NUM_CH-1:0] = dirty;
        case (rd_sel)
            RD_ID:     data_out = (hia == ID_HI_A) ? ID_VAL_A : ID_VAL_B;
            RD_STATUS: data_out = status;
            RD_REG:    data_out = regs_q[reg_idx];
            default:   data_out = 8'hFF;
        endcase
    end

    assign iord_en = (rd_sel != RD_NONE);
    assign iowr_en = cov | (|sd_hit[NUM_CH-1:0]) | (rd_sel == RD_REG);
    assign port_en = rnw ? iord_en : iowr_en;

    always_comb begin
        req_d  = port_req;
        stb_d  = port_req & ~req_q;
        regs_d = regs_q;
        wstb_d = '0;
        if (wr_act && rd_sel == RD_REG) begin
            regs_d[reg_idx] = data_in;
            wstb_d[reg_idx] = 1'b1;
        end
        for (int k = 0; k < NUM_CH; k++) ch_we[k] = wr_act & (cov | sd_hit[k]);
    end

    // req_q resets high so a request already asserted at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b1;
            stb_q  <= 1'b0;
            regs_q <= '0;
            wstb_q <= '0;
        end else begin
            req_q  <= req_d;
            stb_q  <= stb_d;
            regs_q <= regs_d;
            wstb_q <= wstb_d;
        end
    end

    tsxb_dac_buf #(
        .NUM_CH     (NUM_CH),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_dac (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_we       (ch_we),
        .wr_data     (data_in),
        .dac_out     (dac_out),
        .dirty       (dirty),
        .sample_tick (sample_tick)
    );

    assign port_stb  = stb_q;
    assign regs_flat = regs_q;
    assign reg_wstb  = wstb_q;

endmodule

// File: tb/tb_tsxb_port_regs.sv
// tb/tb_tsxb_port_regs.sv - self-checking bench for tsxb_port_regs (buffered and transparent)
module tb_tsxb_port_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        rnw = 1'b1;
    logic        port_req = 1'b1;

    logic [7:0]  data_out, data_out_z;
    logic        port_en, port_en_z, port_stb, port_stb_z;
    logic [31:0] regs_flat, regs_flat_z, dac_out, dac_out_z;
    logic [3:0]  reg_wstb, reg_wstb_z;
    logic        sample_tick, sample_tick_z;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] exp_dac_q[$];

    always #5 clk = ~clk;

    tsxb_port_regs #(.SAMPLE_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out),
        .rnw(rnw), .port_req(port_req), .port_en(port_en), .port_stb(port_stb),
        .regs_flat(regs_flat), .reg_wstb(reg_wstb), .dac_out(dac_out), .sample_tick(sample_tick)
    );

    tsxb_port_regs #(.SAMPLE_DIV(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out_z),
        .rnw(rnw), .port_req(port_req), .port_en(port_en_z), .port_stb(port_stb_z),
        .regs_flat(regs_flat_z), .reg_wstb(reg_wstb_z), .dac_out(dac_out_z), .sample_tick(sample_tick_z)
    );

    // Starts one request and returns at the negedge of its strobe cycle
    task automatic access(input logic [15:0] a, input logic [7:0] d, input logic r);
        @(negedge clk);
        addr = a; data_in = d; rnw = r; port_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (port_stb !== 1'b1) begin
            n_fail++; $display("FAIL access_stb addr=%h: got %b expected 1", a, port_stb);
        end
        port_req = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int g = 0;
        do begin
            @(negedge clk); g++;
        end while (sample_tick !== 1'b1 && g < 20);
        n_tests++;
        if (sample_tick !== 1'b1) begin
            n_fail++; $display("FAIL %s_tick_timeout: got %b expected 1", name, sample_tick);
        end
    endtask

    task automatic test_reset;
        int cnt;
        rst_n = 1'b0; port_req = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({port_stb, reg_wstb, sample_tick, sample_tick_z} !== 7'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0", {port_stb, reg_wstb, sample_tick, sample_tick_z});
        end
        n_tests++;
        if (regs_flat !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 00000000", regs_flat);
        end
        n_tests++;
        if (dac_out !== 32'h80808080 || dac_out_z !== 32'h80808080) begin
            n_fail++; $display("FAIL reset_dac: got %h/%h expected 80808080", dac_out, dac_out_z);
        end
        rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (port_stb) cnt++; end
        n_tests++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL held_req_no_stb: got %0d pulses expected 0", cnt);
        end
        port_req = 1'b0;
        repeat (2) @(negedge clk);
        port_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (port_stb !== 1'b1) begin
            n_fail++; $display("FAIL stb_after_rise: got %b expected 1", port_stb);
        end
        cnt = 0;
        repeat (5) begin @(negedge clk); if (port_stb) cnt++; end
        n_tests++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL stb_single_pulse: got %0d extra pulses expected 0", cnt);
        end
        port_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_registers;
        logic [7:0] e;
        exp_q.push_back(8'h5A);
        access(16'h81AF, 8'h5A, 1'b0);
        n_tests++;
        if (port_en !== 1'b1) begin
            n_fail++; $display("FAIL wr_en_81: got %b expected 1", port_en);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (reg_wstb !== 4'b0010 || regs_flat[15:8] !== e) begin
            n_fail++; $display("FAIL wr_reg1: got wstb=%b val=%h expected 0010/%h", reg_wstb, regs_flat[15:8], e);
        end
        @(negedge clk);
        n_tests++;
        if (reg_wstb !== 4'b0000) begin
            n_fail++; $display("FAIL wstb_one_cycle: got %b expected 0000", reg_wstb);
        end

        exp_q.push_back(8'hC3);
        access(16'h83AF, 8'hC3, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (reg_wstb !== 4'b1000 || regs_flat[31:24] !== e) begin
            n_fail++; $display("FAIL wr_reg3: got wstb=%b val=%h expected 1000/%h", reg_wstb, regs_flat[31:24], e);
        end

        access(16'h84AF, 8'h11, 1'b0);
        n_tests++;
        if (port_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_en_84: got %b expected 0", port_en);
        end
        access(16'h01AF, 8'h22, 1'b0);
        n_tests++;
        if (port_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_en_id: got %b expected 0", port_en);
        end
        @(negedge clk);
        n_tests++;
        if (regs_flat !== 32'hC3005A00 || reg_wstb !== 4'b0000) begin
            n_fail++; $display("FAIL ignored_writes: got %h/%b expected c3005a00/0000", regs_flat, reg_wstb);
        end
    endtask

    task automatic test_reads;
        logic [15:0] ra [7] = '{16'h81AF, 16'h83AF, 16'h80AF, 16'h01AF, 16'h02AF, 16'h07AF, 16'h84AF};
        logic [7:0]  rd [7] = '{8'h5A, 8'hC3, 8'h00, 8'hAA, 8'h55, 8'hFF, 8'hFF};
        logic        re [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0]  e;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(rd[i]);
            access(ra[i], 8'h00, 1'b1);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (data_out !== e || port_en !== re[i]) begin
                n_fail++; $display("FAIL read_%h: got %h en=%b expected %h en=%b", ra[i], data_out, port_en, e, re[i]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (regs_flat !== 32'hC3005A00 || reg_wstb !== 4'b0000) begin
            n_fail++; $display("FAIL read_side_effect: got %h/%b expected c3005a00/0000", regs_flat, reg_wstb);
        end
    endtask

    task automatic test_dac_buffered;
        logic [31:0] e;
        wait_tick("sd1");
        addr = 16'h001F; data_in = 8'h33; rnw = 1'b0; port_req = 1'b1;
        exp_dac_q.push_back(32'h80803380);
        @(negedge clk);
        port_req = 1'b0;
        @(negedge clk);
        addr = 16'h03AF; rnw = 1'b1;
        #1;
        n_tests++;
        if (data_out !== 8'h02 || dac_out !== 32'h80808080 || sample_tick !== 1'b0) begin
            n_fail++; $display("FAIL sd1_pending: got st=%h dac=%h tick=%b expected 02/80808080/0", data_out, dac_out, sample_tick);
        end
        n_tests++;
        if (data_out_z !== 8'h00 || dac_out_z !== 32'h80803380) begin
            n_fail++; $display("FAIL sd1_transparent: got st=%h dac=%h expected 00/80803380", data_out_z, dac_out_z);
        end
        wait_tick("sd1_pub");
        n_tests++;
        if (dac_out !== 32'h80808080) begin
            n_fail++; $display("FAIL sd1_before_tick: got %h expected 80808080", dac_out);
        end
        @(negedge clk);
        e = exp_dac_q.pop_front();
        n_tests++;
        if (dac_out !== e || data_out !== 8'h00) begin
            n_fail++; $display("FAIL sd1_after_tick: got dac=%h st=%h expected %h/00", dac_out, data_out, e);
        end
    endtask

    task automatic test_tick_collision;
        logic [31:0] e;
        @(negedge clk);
        rst_n = 1'b0; port_req = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; port_req = 1'b0;
        wait_tick("cov");
        repeat (3) @(negedge clk);
        addr = 16'h00FB; data_in = 8'h10; rnw = 1'b0; port_req = 1'b1;
        exp_dac_q.push_back(32'h80808080);
        exp_dac_q.push_back(32'h10101010);
        @(negedge clk);
        n_tests++;
        if (port_stb !== 1'b1 || sample_tick !== 1'b1) begin
            n_fail++; $display("FAIL cov_coincide: got stb=%b tick=%b expected 1/1", port_stb, sample_tick);
        end
        port_req = 1'b0;
        @(negedge clk);
        addr = 16'h03AF; rnw = 1'b1;
        #1;
        e = exp_dac_q.pop_front();
        n_tests++;
        if (dac_out !== e || data_out !== 8'h0F) begin
            n_fail++; $display("FAIL cov_held: got dac=%h st=%h expected %h/0f", dac_out, data_out, e);
        end
        wait_tick("cov_next");
        @(negedge clk);
        e = exp_dac_q.pop_front();
        n_tests++;
        if (dac_out !== e || data_out !== 8'h00) begin
            n_fail++; $display("FAIL cov_next_tick: got dac=%h st=%h expected %h/00", dac_out, data_out, e);
        end
    endtask

    task automatic test_transparent;
        access(16'h004F, 8'h77, 1'b0);
        n_tests++;
        if (dac_out_z[23:16] !== 8'h10) begin
            n_fail++; $display("FAIL sd2_early: got %h expected 10", dac_out_z[23:16]);
        end
        @(negedge clk);
        addr = 16'h03AF; rnw = 1'b1;
        #1;
        n_tests++;
        if (dac_out_z !== 32'h10771010 || sample_tick_z !== 1'b1) begin
            n_fail++; $display("FAIL sd2_transparent: got %h tick=%b expected 10771010/1", dac_out_z, sample_tick_z);
        end
        n_tests++;
        if (data_out_z !== 8'h00 || data_out !== 8'h04) begin
            n_fail++; $display("FAIL sd2_dirty: got %h/%h expected 00/04", data_out_z, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_reads();
        test_dac_buffered();
        test_tick_collision();
        test_transparent();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tsxb_port_regs.md
Name: tsxb_port_regs

Overview:
Parametrised successor to the TSXB I/O port decoder. It turns the level port request into a single-cycle edge strobe. It hosts a bank of NUM_REGS read/write control registers behind port xxAF, indexed by the high address byte. It also contains a double-buffered multi-channel DAC latch (Covox/Soundrive) that updates all channel outputs together on an internal sample tick. It sits between the Z80 bus interface and the board's control and audio logic.

Parameters:
TSXB_LO, 8'hAF, low address byte of the register window
REG_BASE, 8'h80, high byte of register 0 (0x80 = test, 0x81 = srpage, for compatibility)
NUM_REGS, 4, number of R/W registers, 1..32; REG_BASE+NUM_REGS <= 256, checked at elaboration
NUM_CH, 4, DAC channels, 1..4
SAMPLE_DIV, 0, clocks per sample tick minus 1; 0 = transparent mode (no buffering)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  16  Z80 port address
data_in  in  8  write data
data_out  out  8  read data (combinational)
rnw  in  1  1 = read cycle
port_req  in  1  level request from bus interface
port_en  out  1  address decoded for the current direction (combinational)
port_stb  out  1  single-cycle registered access strobe
regs_flat  out  8*NUM_REGS  register contents, reg0 at LSBs
reg_wstb  out  NUM_REGS  one-cycle pulse, coincident with the write into that register
dac_out  out  8*NUM_CH  DAC channel values, ch0 at LSBs
sample_tick  out  1  one-cycle tick pulse

Behaviour:
- Reset values:
  - req_d = 1, so a request already high at reset release produces no strobe.
  - port_stb = 0, reg_wstb = 0, regs = 0x00.
  - Pending and dac_out = 0x80 (mid-scale) on all channels.
  - Dirty bits = 0, tick counter = 0, sample_tick = 0.
- Strobe: req_d <= port_req each cycle; port_stb <= port_req & ~req_d.
  - Exactly one pulse per request, one cycle after the rising edge.
  - A request held for N cycles still gives one pulse.
- Decode, with loa = addr[7:0] and hia = addr[15:8]:
  - win = (loa == TSXB_LO).
  - cov = (loa == 8'hFB).
  - sd[k] = loa in {0F, 1F, 4F, 5F} for k = 0..3; channels k >= NUM_CH are ignored.
- Read map (win only):
  - hia 0x01 -> 0xAA; hia 0x02 -> 0x55.
  - hia 0x03 -> status {(8-NUM_CH) zeros, dirty[NUM_CH-1:0]}.
  - hia in [REG_BASE, REG_BASE+NUM_REGS) -> that register.
  - Anything else -> 0xFF.
- Enables:
  - iord_en = win & (hia in read map).
  - iowr_en = cov | any sd | (win & hia in register range).
  - port_en = rnw ? iord_en : iowr_en.
- Writes, taking effect on the port_stb cycle with rnw = 0, using addr/data_in sampled that cycle:
  - Register write: the register updates at the next edge; reg_wstb[i] is registered and high for exactly that one cycle.
  - Writes to ID/status addresses are ignored.
  - Reads have no side effects.
- DAC:
  - Covox write loads data_in into the pending value of every channel and sets all dirty bits.
  - sd[k] write loads channel k only and sets dirty[k].
- Tick (SAMPLE_DIV > 0):
  - Counter runs 0..SAMPLE_DIV and wraps.
  - sample_tick is high for one cycle when the counter equals SAMPLE_DIV.
  - On a tick: dac_out <= pending for all channels together, and dirty clears.
  - Write and tick in the same cycle: dac_out takes the old pending, the new data goes to pending, and its dirty bit stays set; it appears at the next tick.
- Transparent mode (SAMPLE_DIV == 0): sample_tick is high every cycle and dac_out follows pending one cycle after the write; dirty stays 0.
- Reset mid-operation: all state returns to its reset values asynchronously; a request high across deassertion produces no strobe.

Decomposition:
- Package tsxb_pkg:
  - Constants TSXB_LO_DEF, COVOX_LO = 8'hFB, SD_LO[4] = {0F, 1F, 4F, 5F}.
  - ID addresses 0x01/0x02 and values 0xAA/0x55; STATUS_HI = 0x03.
  - DAC_MID = 8'h80.
- Sub-module tsxb_dac_buf: pending/dirty/tick counter/dac_out for NUM_CH channels, with SAMPLE_DIV passed through.

Test Plan:
- Reset with port_req held high, then release -> port_stb stays 0; drop and raise port_req -> exactly one port_stb, one cycle after the rise.
- Write addr 0x81AF, data 0x5A -> regs_flat[15:8] = 0x5A and reg_wstb = 4'b0010 for one cycle; read 0x81AF -> data_out = 0x5A, port_en = 1.
- Read 0x01AF, 0x02AF and 0x07AF -> data_out 0xAA, 0x55, 0xFF; port_en 1, 1, 0.
- SAMPLE_DIV = 3: write 0x1F (ch1) = 0x33 -> status reads 0x02 and dac_out is unchanged until sample_tick; then ch1 = 0x33, other channels 0x80, status 0x00.
- Covox write 0x10 coincident with a tick while pending = 0x80 -> dac_out stays 0x80 at that tick and becomes 0x10 on all channels at the next tick.
- SAMPLE_DIV = 0: sd 0x4F write 0x77 -> dac_out ch2 = 0x77 one cycle after port_stb.
